// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | fifo_ctrl_pkg : constants and state encoding shared by the FIFO controllers
// | rev 1.0
// +---------------------------------------------------------------------------
package fifo_ctrl_pkg;

  localparam int DEF_DEPTH     = 512;
  localparam int DEF_BURST_LEN = 100;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CHECK     = 4'd1;
  localparam logic [3:0] ST_REQ       = 4'd2;
  localparam logic [3:0] ST_WAIT_DONE = 4'd3;
  localparam logic [3:0] ST_FSH       = 4'd4;
  localparam logic [3:0] ST_FRAME_END = 4'd5;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_CHECK     = ST_CHECK,
    S_REQ       = ST_REQ,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_FSH       = ST_FSH,
    S_FRAME_END = ST_FRAME_END
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_space_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | fifo_space_ctrl_if : scheduler / read-engine handshake bundle
// | timeout_err present only with FIFO_SPACE_TIMEOUT_EN.  rev 1.0
// +---------------------------------------------------------------------------
interface fifo_space_ctrl_if #(
  parameter int CSIZE = 10,
  parameter int LSIZE = 9,
  parameter int FSIZE = 24
);
  logic [CSIZE-1:0] count;
  logic             frame_req;
  logic [FSIZE-1:0] frame_len;
  logic             burst_req;
  logic [LSIZE-1:0] req_len;
  logic             resp;
  logic             done;
  logic             burst_done;
  logic             frame_done;
  logic             busy;
`ifdef FIFO_SPACE_TIMEOUT_EN
  logic             timeout_err;
`endif

  modport master (
    input  count, frame_req, frame_len, resp, done,
    output burst_req, req_len, burst_done, frame_done, busy
`ifdef FIFO_SPACE_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport slave (
    output count, frame_req, frame_len, resp, done,
    input  burst_req, req_len, burst_done, frame_done, busy
`ifdef FIFO_SPACE_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fifo_space_calc.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | fifo_space_calc : registered next burst length and FIFO room check
// | rev 1.0
// +---------------------------------------------------------------------------
module fifo_space_calc
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CSIZE     = 10,
  parameter int LSIZE     = 9,
  parameter int FSIZE     = 24
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [CSIZE-1:0] count,
  input  logic [FSIZE-1:0] remaining,
  output logic [LSIZE-1:0] next_len,
  output logic             space_ok
);

  localparam int               W       = (CSIZE + 1 > LSIZE) ? CSIZE + 1 : LSIZE;
  localparam logic [CSIZE:0]   C_DEPTH = (CSIZE + 1)'(DEPTH);
  localparam logic [FSIZE-1:0] C_BURST = FSIZE'(BURST_LEN);

  logic [LSIZE-1:0] len_d, len_q;
  logic [CSIZE:0]   count_ext_w, free_w;
  logic             in_range_w, ok_d, ok_q;

  // One extra bit keeps DEPTH - count from wrapping; an overfull count never grants room.
  always_comb begin
    len_d       = LSIZE'((remaining < C_BURST) ? remaining : C_BURST);
    count_ext_w = {1'b0, count};
    in_range_w  = (count_ext_w <= C_DEPTH);
    free_w      = C_DEPTH - count_ext_w;
    ok_d        = in_range_w && (W'(free_w) >= W'(len_d));
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      len_q <= len_d;
      ok_q  <= ok_d;
    end
  end

  assign next_len = len_q;
  assign space_ok = ok_q;

endmodule
`default_nettype wire

// File: rtl/fifo_space_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | fifo_space_ctrl : issues read bursts only when the read FIFO has room
// | Optional done watchdog: FIFO_SPACE_TIMEOUT_EN.  rev 1.0
// +---------------------------------------------------------------------------
module fifo_space_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CSIZE     = 10,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int LSIZE     = 9,
  parameter int FSIZE     = 24
`ifdef FIFO_SPACE_TIMEOUT_EN
  , parameter int TIMEOUT = 4096
`endif
) (
  input  logic              clock,
  input  logic              rst,
  fifo_space_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [FSIZE-1:0] remaining_q, remaining_d;
  logic [LSIZE-1:0] req_len_q, next_len_q;
  logic             space_ok_q;
  logic             burst_req_q, burst_done_q, frame_done_q, busy_q;

`ifdef FIFO_SPACE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt_q;
  logic          timeout_err_q;
  logic          w_expire;
`endif

  // Fed with remaining_d so the room check seen in CHECK already reflects the new remainder.
  fifo_space_calc #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN),
    .CSIZE     (CSIZE),
    .LSIZE     (LSIZE),
    .FSIZE     (FSIZE)
  ) u_calc (
    .clock     (clock),
    .rst       (rst),
    .count     (bus.count),
    .remaining (remaining_d),
    .next_len  (next_len_q),
    .space_ok  (space_ok_q)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
`ifdef FIFO_SPACE_TIMEOUT_EN
    w_expire    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.frame_req) begin
          remaining_d = bus.frame_len;
          state_d     = (bus.frame_len == '0) ? S_FRAME_END : S_CHECK;
        end
      end
      S_CHECK: begin
        if (space_ok_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.resp) state_d = bus.done ? S_FSH : S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.done) begin
          state_d = S_FSH;
        end
`ifdef FIFO_SPACE_TIMEOUT_EN
        else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d     = S_FRAME_END;
          remaining_d = '0;
          w_expire    = 1'b1;
        end
`endif
      end
      S_FSH: begin
        remaining_d = remaining_q - FSIZE'(req_len_q);
        state_d     = (remaining_d != '0) ? S_CHECK : S_FRAME_END;
      end
      S_FRAME_END: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state_d so they line up with the cycle spent in that state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      req_len_q     <= '0;
      burst_req_q   <= 1'b0;
      burst_done_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FIFO_SPACE_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      burst_req_q  <= (state_d == S_REQ);
      burst_done_q <= (state_d == S_FSH);
      frame_done_q <= (state_d == S_FRAME_END);
      busy_q       <= (state_d != S_IDLE);
      if (state_d == S_REQ && state_q != S_REQ) begin
        req_len_q <= next_len_q;
      end else if (state_d != S_REQ && state_d != S_WAIT_DONE && state_d != S_FSH) begin
        req_len_q <= '0;
      end
`ifdef FIFO_SPACE_TIMEOUT_EN
      if (state_d == S_WAIT_DONE && state_q != S_WAIT_DONE) begin
        wd_cnt_q <= '0;
      end else if (state_q == S_WAIT_DONE) begin
        wd_cnt_q <= wd_cnt_q + TW'(1);
      end
      timeout_err_q <= w_expire;
`endif
    end
  end

  assign bus.burst_req  = burst_req_q;
  assign bus.req_len    = req_len_q;
  assign bus.burst_done = burst_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
`ifdef FIFO_SPACE_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`endif

endmodule
`default_nettype wire
